// File: rtl/reg_bridge_pkg.sv
// Shared types and defaults for the reg_native_if -> APB bridge.
// Latency: n/a (definitions only). Backpressure: n/a.
package reg_bridge_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 64;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK
  } bridge_state_e;

  localparam logic [DEF_DATA_WIDTH-1:0] ERR_RD_DATA = '0;

  // Exactly one of read/write must be requested for an APB transfer to start.
  function automatic logic is_legal(input logic wr, input logic rd);
    return wr ^ rd;
  endfunction

endpackage

// File: rtl/apb_bridge_timer.sv
// ACCESS-phase watchdog: counts cycles since clear, flags the LIMIT-th cycle.
// Latency: expired_o is registered-count based, high during the LIMIT-th enabled cycle.
// Backpressure: none; counter saturates at the expiry value.
module apb_bridge_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT < 256) ? 8 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_native_apb_bridge.sv
// reg_native_if responder -> APB initiator, one request in flight; optional ACCESS
// timeout under `REG_APB_BRIDGE_TIMEOUT_EN. Accept->ack is 3 cycles plus PREADY waits;
// req_rdy is low from accept until the ack is taken, ack_vld holds until ack_rdy.
module reg_native_apb_bridge
  import reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  input  logic                  ack_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  bus_err
);

  bridge_state_e         state_q, state_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  ack_vld_q, ack_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  timeout_hit;

`ifdef REG_APB_BRIDGE_TIMEOUT_EN
  apb_bridge_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == SETUP),
    .en_i     (state_q == ACCESS),
    .expired_o(timeout_hit)
  );
`else
  // Without the watchdog ACCESS waits on PREADY forever.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_vld && req_rdy_q) begin
          paddr_d  = addr;
          pwdata_d = wr_data;
          pwrite_d = wr_en;
          if (is_legal(wr_en, rd_en)) begin
            state_d = SETUP;
          end else begin
            state_d   = ACK;
            rd_data_d = DATA_WIDTH'(ERR_RD_DATA);
            bus_err_d = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = ACK;
          if (PSLVERR) begin
            rd_data_d = DATA_WIDTH'(ERR_RD_DATA);
            bus_err_d = 1'b1;
          end else if (pwrite_q) begin
            rd_data_d = '0;
          end else begin
            rd_data_d = PRDATA;
          end
        end else if (timeout_hit) begin
          state_d   = ACK;
          rd_data_d = DATA_WIDTH'(ERR_RD_DATA);
          bus_err_d = 1'b1;
        end
      end
      ACK: begin
        if (ack_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake and APB strobes are registered copies of the next state.
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    ack_vld_d = (state_d == ACK);
    req_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_rdy_q <= 1'b1;
      ack_vld_q <= 1'b0;
      rd_data_q <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_rdy_q <= req_rdy_d;
      ack_vld_q <= ack_vld_d;
      rd_data_q <= rd_data_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign req_rdy = req_rdy_q;
  assign ack_vld = ack_vld_q;
  assign rd_data = rd_data_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign bus_err = bus_err_q;

endmodule
